// File: rtl/chi_refill_responder_if.sv
// rtl/chi_refill_responder_if.sv - MSHR-side and memory-side handshake bundle for the refill responder
interface chi_refill_responder_if #(
   parameter int MSHR_NUM = 4,
   parameter int PADDR_W  = 40
);
   logic [MSHR_NUM-1:0]         mshr_req_valid;
   logic [MSHR_NUM*PADDR_W-1:0] mshr_req_paddr;
   logic [MSHR_NUM-1:0]         mshr_req_ready;
   logic [MSHR_NUM-1:0]         mshr_resp_valid;
   logic [511:0]                mshr_resp_data;
   logic                        mem_req_valid;
   logic                        mem_req_ready;
   logic [PADDR_W-1:0]          mem_req_addr;
   logic                        mem_resp_valid;
   logic [63:0]                 mem_resp_data;
   logic                        mem_resp_last;

   modport slave (
      input  mshr_req_valid, mshr_req_paddr, mem_req_ready,
             mem_resp_valid, mem_resp_data, mem_resp_last,
      output mshr_req_ready, mshr_resp_valid, mshr_resp_data,
             mem_req_valid, mem_req_addr
   );

   modport master (
      output mshr_req_valid, mshr_req_paddr, mem_req_ready,
             mem_resp_valid, mem_resp_data, mem_resp_last,
      input  mshr_req_ready, mshr_resp_valid, mshr_resp_data,
             mem_req_valid, mem_req_addr
   );
endinterface

// File: rtl/chi_refill_responder.sv
// rtl/chi_refill_responder.sv - round-robin MSHR refill arbiter that fetches one 8x64b line at a time
module chi_refill_responder #(
   parameter int MSHR_NUM     = 4,
   parameter int MSHR_NUM_LOG = 2,
   parameter int PADDR_W      = 40
) (
   input  logic                    clock,
   input  logic                    reset_n,
   chi_refill_responder_if.slave   bus,
   output logic                    busy,
   output logic                    beat_err
);
   typedef enum logic [1:0] {IDLE, S_MEMREQ, W_BEATS, S_RESP} state_t;

   state_t                  state;
   logic [MSHR_NUM_LOG-1:0] rr_ptr;
   logic [MSHR_NUM_LOG-1:0] cur_id;
   logic [2:0]              cnt;
   logic [PADDR_W-1:0]      addr_q;
   logic [511:0]            line;
   logic [511:0]            resp_data_q;
   logic [MSHR_NUM-1:0]     resp_valid_q;
   logic                    mem_req_valid_q;

   logic [MSHR_NUM-1:0]     grant;
   logic [MSHR_NUM_LOG-1:0] gid;
   logic [MSHR_NUM_LOG-1:0] idx;
   logic                    found;
   logic [PADDR_W-1:0]      sel_paddr;
   logic [MSHR_NUM-1:0]     cur_onehot;

   // Grant is masked during reset so every output reads zero while reset_n is low.
   always_comb begin
      grant = '0;
      gid   = '0;
      idx   = '0;
      found = 1'b0;
      if (state == IDLE && reset_n) begin
         for (int i = 0; i < MSHR_NUM; i++) begin
            idx = rr_ptr + i[MSHR_NUM_LOG-1:0];
            if (!found && bus.mshr_req_valid[idx]) begin
               found = 1'b1;
               gid   = idx;
            end
         end
         if (found) grant[gid] = 1'b1;
      end
   end

   assign sel_paddr  = bus.mshr_req_paddr[gid*PADDR_W +: PADDR_W];
   assign cur_onehot = {{(MSHR_NUM-1){1'b0}}, 1'b1} << cur_id;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         rr_ptr          <= '0;
         cur_id          <= '0;
         cnt             <= '0;
         addr_q          <= '0;
         line            <= '0;
         resp_data_q     <= '0;
         resp_valid_q    <= '0;
         mem_req_valid_q <= 1'b0;
         busy            <= 1'b0;
         beat_err        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  cur_id          <= gid;
                  addr_q          <= {sel_paddr[PADDR_W-1:6], 6'b0};
                  rr_ptr          <= gid + 1'b1;
                  mem_req_valid_q <= 1'b1;
                  busy            <= 1'b1;
                  state           <= S_MEMREQ;
               end
            end
            S_MEMREQ: begin
               if (bus.mem_req_ready) begin
                  mem_req_valid_q <= 1'b0;
                  cnt             <= '0;
                  state           <= W_BEATS;
               end
            end
            W_BEATS: begin
               if (bus.mem_resp_valid) begin
                  line[{cnt, 6'b0} +: 64] <= bus.mem_resp_data;
                  cnt                     <= cnt + 3'd1;
                  // Length errors are flagged only; completion always follows the 8th beat.
                  if (bus.mem_resp_last != (cnt == 3'd7)) beat_err <= 1'b1;
                  if (cnt == 3'd7) begin
                     resp_data_q  <= {bus.mem_resp_data, line[447:0]};
                     resp_valid_q <= cur_onehot;
                     state        <= S_RESP;
                  end
               end
            end
            S_RESP: begin
               resp_valid_q <= '0;
               busy         <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.mshr_req_ready  = grant;
   assign bus.mshr_resp_valid = resp_valid_q;
   assign bus.mshr_resp_data  = resp_data_q;
   assign bus.mem_req_valid   = mem_req_valid_q;
   assign bus.mem_req_addr    = addr_q;
endmodule

// File: doc/chi_refill_responder.md
CHI_REFILL_RESPONDER -- requirements
Module: chi_refill_responder

Interface
REQ-001 Parameter MSHR_NUM, default 4, sets the number of MSHR requesters served (power of two, 2..16).
REQ-002 Parameter MSHR_NUM_LOG, default 2, SHALL equal log2(MSHR_NUM).
REQ-003 The block has one clock and an asynchronous active-low reset; the ports SHALL be: clock  in  1  clock; reset_n  in  1  async active-low reset.
REQ-004 mshr_req_valid  in  MSHR_NUM  per-entry refill request.
REQ-005 mshr_req_paddr  in  MSHR_NUM*PADDR width (`PADDR_RANGE)  per-entry physical address, entry i at slice i.
REQ-006 mshr_req_ready  out  MSHR_NUM  one-hot grant/accept.
REQ-007 mshr_resp_valid  out  MSHR_NUM  one-hot refill-complete pulse.
REQ-008 mshr_resp_data  out  512  assembled cache line.
REQ-009 mem_req_valid  out  1; mem_req_ready  in  1; mem_req_addr  out  `PADDR_RANGE  line-aligned downstream read request.
REQ-010 mem_resp_valid  in  1; mem_resp_data  in  64; mem_resp_last  in  1  downstream read beat.
REQ-011 busy  out  1  transaction in flight; beat_err  out  1  sticky beat-count error.

Function
REQ-012 The FSM SHALL have states IDLE, S_MEMREQ, W_BEATS, S_RESP; only one transaction outstanding.
REQ-013 In IDLE, mshr_req_ready SHALL be a combinational one-hot grant to the first requester with valid set, searching upward from rr_ptr with wrap-around; all-zero when no valid or not IDLE.
REQ-014 On accept (valid&ready of entry g), the block SHALL capture g as cur_id, capture paddr with bits [5:0] forced to zero, set rr_ptr = (g+1) mod MSHR_NUM, and go to S_MEMREQ.
REQ-015 In S_MEMREQ, mem_req_valid=1 and mem_req_addr=captured address, held stable until mem_req_ready; on handshake go to W_BEATS with beat counter cleared.
REQ-016 In W_BEATS, each mem_resp_valid beat SHALL write mem_resp_data into line[64*cnt+63:64*cnt] and increment the 3-bit counter; beats outside W_BEATS are ignored.
REQ-017 Transaction completes on the 8th beat (cnt==7); next cycle is S_RESP.
REQ-018 If mem_resp_last arrives with cnt!=7, or cnt==7 arrives without mem_resp_last, beat_err SHALL set and remain set until reset; the 8-beat completion rule is unchanged.
REQ-019 In S_RESP, mshr_resp_valid[cur_id]=1 for exactly one cycle with mshr_resp_data=assembled line; then IDLE.
REQ-020 mshr_resp_data SHALL hold the last line between responses; it is valid only while mshr_resp_valid is set.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 Latency: accept at cycle T -> mem_req_valid at T+1; last beat at B -> mshr_resp_valid at B+1 -> next grant possible at B+2.
REQ-023 A requester dropping valid before grant SHALL simply not be granted; no state retained for it.
REQ-024 mem_req_ready asserted outside S_MEMREQ SHALL have no effect.

Reset
REQ-025 On reset_n low, asynchronously: state=IDLE, rr_ptr=0, cnt=0, cur_id=0, captured address=0, line=0, beat_err=0; all outputs 0.
REQ-026 Reset mid-transaction SHALL abandon it; no response is issued and no request is reissued after reset release.

Verification
REQ-027 Single request: entry 1 valid, paddr 0x8000_1234 -> ready[1] same cycle, mem_req_addr 0x8000_1200 next cycle; 8 beats 0x0..0x7 -> resp_valid=4'b0010 one cycle, data beat k at bits [64k+63:64k].
REQ-028 Round-robin: entries 0,2,3 valid continuously from reset -> grant order 0,2,3,0.
REQ-029 Backpressure: mem_req_ready low 5 cycles -> mem_req_valid and addr held stable, no beats consumed, busy=1.
REQ-030 Early last: mem_resp_last on beat 4 -> beat_err=1 and stays 1; response still issued after beat 8.
REQ-031 Reset during W_BEATS after 3 beats -> all outputs 0 immediately; no resp_valid after release; a new request is granted normally with cnt starting at 0.
REQ-032 Stray beats in IDLE and mem_req_ready in W_BEATS -> no state change, no response.
